mpu_i2c_responder: RTL and testbench



---
 rtl/mpu_regs_pkg.sv | 41 ++++
 rtl/i2c_cond_detect.sv | 45 ++++
 rtl/mpu_i2c_responder.sv | 197 +++++++++++++++++++
 tb/tb_mpu_i2c_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_regs_pkg.sv
// Shared definitions for the MPU-6050 I2C responder: register map, FSM states
// and the snapshot byte selector.
package mpu_regs_pkg;

    localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
    localparam logic [7:0] GYRO_ZOUT_L  = 8'h48;
    localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
    localparam logic [7:0] WHO_AM_I     = 8'h75;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h68;

    localparam int SNAP_BYTES = 14;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK_WAIT,
        ST_IGNORE
    } state_t;

    // Snapshot is packed {AcX, AcY, AcZ, Tmp, GyX, GyY, GyZ}, so register 0x3B is the top byte.
    function automatic logic [7:0] snap_byte(input logic [111:0] snap, input logic [7:0] addr);
        logic [7:0] off;
        logic [7:0] res;
        off = addr - ACCEL_XOUT_H;
        res = 8'h00;
        for (int i = 0; i < SNAP_BYTES; i++) begin
            if (off == 8'(i)) begin
                res = snap[(SNAP_BYTES - 1 - i) * 8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/i2c_cond_detect.sv
// Synchronizes SCL/SDA into clk and derives edge and START/STOP pulses
// from the synchronized copies.
module i2c_cond_detect (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] raw;
    logic [1:0] meta_reg;
    logic [1:0] sync_reg;
    logic [1:0] hist_reg;

    assign raw = {scl, sda};

    // Bus idles high, so reset the chain to 1 to avoid a phantom edge at release.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg[gi] <= 1'b1;
                    sync_reg[gi] <= 1'b1;
                    hist_reg[gi] <= 1'b1;
                end else begin
                    meta_reg[gi] <= raw[gi];
                    sync_reg[gi] <= meta_reg[gi];
                    hist_reg[gi] <= sync_reg[gi];
                end
            end
        end
    endgenerate

    assign sda_s    = sync_reg[0];
    assign scl_rise =  sync_reg[1] & ~hist_reg[1];
    assign scl_fall = ~sync_reg[1] &  hist_reg[1];
    assign start    =  sync_reg[1] &  hist_reg[1] &  hist_reg[0] & ~sync_reg[0];
    assign stop     =  sync_reg[1] &  hist_reg[1] & ~hist_reg[0] &  sync_reg[0];

endmodule

// File: rtl/mpu_i2c_responder.sv
// I2C slave model of the MPU-6050 register interface: address match, register
// pointer, PWR_MGMT_1 writes and coherent snapshot burst reads.
module mpu_i2c_responder
    import mpu_regs_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR     = DEV_ADDR_DEFAULT,
    parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
    parameter logic [7:0] PWR_RST      = 8'h40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCL,
    inout  wire         SDA,
    input  logic [15:0] AcX,
    input  logic [15:0] AcY,
    input  logic [15:0] AcZ,
    input  logic [15:0] Tmp,
    input  logic [15:0] GyX,
    input  logic [15:0] GyY,
    input  logic [15:0] GyZ,
    output logic [7:0]  pwr_mgmt,
    output logic        wr_strobe,
    output logic        busy
);

    logic sda_s, scl_rise, scl_fall, start, stop;

    i2c_cond_detect u_cond (
        .clk      (clk),
        .rst      (rst),
        .scl      (SCL),
        .sda      (SDA),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    state_t        state_reg;
    logic [3:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic [7:0]    tx_reg;
    logic [7:0]    ptr_reg;
    logic [111:0]  snap_reg;
    logic [7:0]    pwr_reg;
    logic          wr_strobe_reg;
    logic          busy_reg;
    logic          sda_low_reg;
    logic          rw_reg;

    logic [7:0]    byte_in;
    logic [7:0]    rd_data;

    assign byte_in = {shift_reg[6:0], sda_s};

    always_comb begin
        rd_data = 8'h00;
        if (ptr_reg >= ACCEL_XOUT_H && ptr_reg <= GYRO_ZOUT_L) begin
            rd_data = snap_byte(snap_reg, ptr_reg);
        end else if (ptr_reg == PWR_MGMT_1) begin
            rd_data = pwr_reg;
        end else if (ptr_reg == WHO_AM_I) begin
            rd_data = WHO_AM_I_VAL;
        end
    end

    // In the ACK states sda_low_reg doubles as the phase flag: the first SCL fall
    // after the 8th bit starts the ACK, the second one ends it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 4'd0;
            shift_reg     <= 8'h00;
            tx_reg        <= 8'h00;
            ptr_reg       <= 8'h00;
            snap_reg      <= '0;
            pwr_reg       <= PWR_RST;
            wr_strobe_reg <= 1'b0;
            busy_reg      <= 1'b0;
            sda_low_reg   <= 1'b0;
            rw_reg        <= 1'b0;
        end else begin
            wr_strobe_reg <= 1'b0;
            if (stop) begin
                state_reg   <= ST_IDLE;
                bit_cnt_reg <= 4'd0;
                sda_low_reg <= 1'b0;
                busy_reg    <= 1'b0;
            end else if (start) begin
                state_reg   <= ST_ADDR;
                bit_cnt_reg <= 4'd0;
                sda_low_reg <= 1'b0;
            end else begin
                unique case (state_reg)
                    ST_ADDR: if (scl_rise) begin
                        shift_reg   <= byte_in;
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            if (byte_in[7:1] == DEV_ADDR) begin
                                busy_reg  <= 1'b1;
                                rw_reg    <= byte_in[0];
                                state_reg <= ST_ADDR_ACK;
                                if (byte_in[0]) begin
                                    snap_reg <= {AcX, AcY, AcZ, Tmp, GyX, GyY, GyZ};
                                end
                            end else begin
                                busy_reg  <= 1'b0;
                                state_reg <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: if (scl_fall) begin
                        if (!sda_low_reg) begin
                            sda_low_reg <= 1'b1;
                        end else begin
                            bit_cnt_reg <= 4'd0;
                            if (rw_reg) begin
                                tx_reg      <= rd_data;
                                sda_low_reg <= ~rd_data[7];
                                state_reg   <= ST_RDATA;
                            end else begin
                                sda_low_reg <= 1'b0;
                                state_reg   <= ST_PTR;
                            end
                        end
                    end
                    ST_PTR: if (scl_rise) begin
                        shift_reg   <= byte_in;
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            ptr_reg   <= byte_in;
                            state_reg <= ST_PTR_ACK;
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                        if (!sda_low_reg) begin
                            sda_low_reg <= 1'b1;
                        end else begin
                            sda_low_reg <= 1'b0;
                            bit_cnt_reg <= 4'd0;
                            state_reg   <= ST_WDATA;
                        end
                    end
                    ST_WDATA: if (scl_rise) begin
                        shift_reg   <= byte_in;
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            if (ptr_reg == PWR_MGMT_1) begin
                                pwr_reg       <= byte_in;
                                wr_strobe_reg <= 1'b1;
                            end
                            ptr_reg   <= ptr_reg + 8'd1;
                            state_reg <= ST_WDATA_ACK;
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            if (bit_cnt_reg == 4'd7) begin
                                ptr_reg <= ptr_reg + 8'd1;
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt_reg == 4'd8) begin
                                sda_low_reg <= 1'b0;
                                state_reg   <= ST_RACK_WAIT;
                            end else begin
                                tx_reg      <= {tx_reg[6:0], 1'b0};
                                sda_low_reg <= ~tx_reg[6];
                            end
                        end
                    end
                    // Entered on a fall, so the next fall always follows the master's ACK bit.
                    ST_RACK_WAIT: begin
                        if (scl_rise && sda_s) begin
                            state_reg <= ST_IGNORE;
                        end else if (scl_fall) begin
                            tx_reg      <= rd_data;
                            sda_low_reg <= ~rd_data[7];
                            bit_cnt_reg <= 4'd0;
                            state_reg   <= ST_RDATA;
                        end
                    end
                    ST_IDLE, ST_IGNORE: begin
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign SDA       = (sda_low_reg && !rst) ? 1'b0 : 1'bz;
    assign pwr_mgmt  = pwr_reg;
    assign wr_strobe = wr_strobe_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_mpu_i2c_responder.sv
// Directed bench for mpu_i2c_responder: a bit-banged I2C master issues frames and
// queues the expected bus bytes; an independent bus monitor checks each 9-bit frame.
`timescale 1ns/1ps
module tb_mpu_i2c_responder;

    localparam int Q = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        sda_m_low = 1'b0;
    wire         sda;
    logic [15:0] acx = 16'h0000, acy = 16'h0000, acz = 16'h0000, tmp = 16'h0000;
    logic [15:0] gyx = 16'h0000, gyy = 16'h0000, gyz = 16'h0000;
    logic [7:0]  pwr_mgmt;
    logic        wr_strobe;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       ack;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign sda = sda_m_low ? 1'b0 : 1'bz;
    pullup (sda);

    mpu_i2c_responder dut (
        .clk       (clk),
        .rst       (rst),
        .SCL       (scl),
        .SDA       (sda),
        .AcX       (acx),
        .AcY       (acy),
        .AcZ       (acz),
        .Tmp       (tmp),
        .GyX       (gyx),
        .GyY       (gyy),
        .GyZ       (gyz),
        .pwr_mgmt  (pwr_mgmt),
        .wr_strobe (wr_strobe),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) strobe_cnt++;
    end

    // Bus monitor: frames are reassembled from the wire, independent of the master tasks.
    initial begin
        logic       prev_scl, prev_sda, ackb;
        logic [7:0] cur;
        int         nbits;
        exp_t       e;
        prev_scl = 1'b1;
        prev_sda = 1'b1;
        cur      = 8'h00;
        nbits    = 0;
        forever begin
            @(negedge clk);
            if (scl && prev_scl && prev_sda && !sda) begin
                nbits = 0;
            end else if (scl && prev_scl && !prev_sda && sda) begin
                nbits = 0;
            end else if (scl && !prev_scl) begin
                if (nbits < 8) begin
                    cur = {cur[6:0], sda};
                    nbits++;
                end else begin
                    ackb  = sda;
                    nbits = 0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame: got data 0x%02h ack %0b want no frame", cur, ackb);
                    end else begin
                        e = exp_q.pop_front();
                        $display("frame %s data=0x%02h ack=%0b", e.name, cur, ackb);
                        check({e.name, "_data"}, {24'h0, cur}, {24'h0, e.data});
                        check({e.name, "_ack"}, {31'h0, ackb}, {31'h0, e.ack});
                    end
                end
            end
            prev_scl = scl;
            prev_sda = sda;
        end
    end

    task automatic bit_cycle(input logic b);
        #(Q) sda_m_low = ~b;
        #(Q) scl = 1'b1;
        #(2*Q) scl = 1'b0;
    endtask

    task automatic i2c_start();
        #(Q) sda_m_low = 1'b0;
        #(Q) scl = 1'b1;
        #(Q) sda_m_low = 1'b1;
        #(Q) scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #(Q) sda_m_low = 1'b1;
        #(Q) scl = 1'b1;
        #(Q) sda_m_low = 1'b0;
        #(Q);
    endtask

    task automatic write_byte(input string name, input logic [7:0] d, input logic exp_ack);
        exp_q.push_back('{name, d, exp_ack});
        for (int i = 7; i >= 0; i--) bit_cycle(d[i]);
        bit_cycle(1'b1);
    endtask

    task automatic read_byte(input string name, input logic [7:0] exp_d, input logic m_ack);
        exp_q.push_back('{name, exp_d, m_ack});
        for (int i = 0; i < 8; i++) bit_cycle(1'b1);
        bit_cycle(m_ack);
    endtask

    task automatic align();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int s0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_pwr", {24'h0, pwr_mgmt}, 32'h40);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_strobe", {31'h0, wr_strobe}, 32'h0);
        check("rst_sda", {31'h0, sda}, 32'h1);
        rst = 1'b0;
        repeat (4) align();

        // 1: write PWR_MGMT_1 = 0x00
        s0 = strobe_cnt;
        i2c_start();
        write_byte("t1_addr", 8'hD0, 1'b0);
        check("t1_busy_on", {31'h0, busy}, 32'h1);
        write_byte("t1_ptr", 8'h6B, 1'b0);
        write_byte("t1_data", 8'h00, 1'b0);
        i2c_stop();
        #(Q);
        check("t1_pwr", {24'h0, pwr_mgmt}, 32'h00);
        check("t1_strobes", strobe_cnt - s0, 32'd1);
        check("t1_busy_off", {31'h0, busy}, 32'h0);

        // 2: WHO_AM_I via repeated START
        s0 = strobe_cnt;
        i2c_start();
        write_byte("t2_addr_w", 8'hD0, 1'b0);
        write_byte("t2_ptr", 8'h75, 1'b0);
        i2c_start();
        write_byte("t2_addr_r", 8'hD1, 1'b0);
        read_byte("t2_whoami", 8'h68, 1'b1);
        i2c_stop();
        check("t2_strobes", strobe_cnt - s0, 32'd0);

        // 3: coherent snapshot burst
        acx = 16'hCA5A;
        acy = 16'h5AF0;
        i2c_start();
        write_byte("t3_addr_w", 8'hD0, 1'b0);
        write_byte("t3_ptr", 8'h3B, 1'b0);
        i2c_start();
        write_byte("t3_addr_r", 8'hD1, 1'b0);
        read_byte("t3_b0", 8'hCA, 1'b0);
        acx = 16'h1234;
        read_byte("t3_b1", 8'h5A, 1'b0);
        read_byte("t3_b2", 8'h5A, 1'b0);
        read_byte("t3_b3", 8'hF0, 1'b1);
        i2c_stop();

        // 4: foreign address is ignored
        s0 = strobe_cnt;
        i2c_start();
        write_byte("t4_addr", 8'hA0, 1'b1);
        check("t4_busy", {31'h0, busy}, 32'h0);
        write_byte("t4_ptr", 8'h6B, 1'b1);
        write_byte("t4_data", 8'h55, 1'b1);
        i2c_stop();
        check("t4_pwr", {24'h0, pwr_mgmt}, 32'h00);
        check("t4_strobes", strobe_cnt - s0, 32'd0);

        // 5: pointer wraps 0xFF -> 0x00
        i2c_start();
        write_byte("t5_addr_w", 8'hD0, 1'b0);
        write_byte("t5_ptr", 8'hFF, 1'b0);
        i2c_start();
        write_byte("t5_addr_r", 8'hD1, 1'b0);
        read_byte("t5_b0", 8'h00, 1'b0);
        read_byte("t5_b1", 8'h00, 1'b1);
        i2c_stop();
        check("t5_ptr_after", {24'h0, dut.ptr_reg}, 32'h01);

        // 6: reset during the 4th bit of a WHO_AM_I read (that bit is 0)
        i2c_start();
        write_byte("t6_addr_w", 8'hD0, 1'b0);
        write_byte("t6_ptr", 8'h75, 1'b0);
        i2c_start();
        write_byte("t6_addr_r", 8'hD1, 1'b0);
        for (int i = 0; i < 3; i++) bit_cycle(1'b1);
        #(Q);
        check("t6_sda_driven", {31'h0, sda}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_sda_released", {31'h0, sda}, 32'h1);
        repeat (2) @(negedge clk);
        #1;
        check("t6_busy", {31'h0, busy}, 32'h0);
        check("t6_pwr", {24'h0, pwr_mgmt}, 32'h40);
        rst = 1'b0;
        align();
        i2c_stop();
        i2c_start();
        write_byte("t6n_addr_w", 8'hD0, 1'b0);
        write_byte("t6n_ptr", 8'h75, 1'b0);
        i2c_start();
        write_byte("t6n_addr_r", 8'hD1, 1'b0);
        read_byte("t6n_whoami", 8'h68, 1'b1);
        i2c_stop();
        check("t6n_busy", {31'h0, busy}, 32'h0);

        repeat (8) @(posedge clk);
        check("frames_left", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
